// File: rtl/rr_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Package     : rr_scheduler_pkg
// Description : Shared control definitions for the round-robin scheduler.
//               Holds the scheduler state encoding and the default
//               grant-hold timeout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rr_scheduler_pkg;

  // Scheduler control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Default maximum number of cycles a grant may be held before forced release
  localparam int TIMEOUT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/circular_adder.sv
//------------------------------------------------------------------------------
// Module      : circular_adder
// Description : Registered wrap-around successor. When enable_i is high the
//               stored value is loaded with base_i+1, wrapping to 0 once
//               base_i reaches max_i (or exceeds it).
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-low reset (value -> 0)
//               enable_i - load strobe
//               max_i    - highest value before wrap
//               base_i   - value to advance from
//               value_o  - stored value
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module circular_adder #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] base_i,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // ">=" rather than "==" so a base left stranded above a lowered max
  // still wraps to 0.
  assign value_d = (base_i >= max_i) ? '0 : base_i + WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else if (enable_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/rr_scheduler.sv
//------------------------------------------------------------------------------
// Module      : rr_scheduler
// Description : Round-robin scheduler granting one shared resource to one of
//               N_REQ requesters. A grant is issued from IDLE, held in BUSY
//               until the resource pulses done, and the search pointer then
//               moves past the released requester.
//               Optional feature macro: RR_SCHEDULER_TIMEOUT_EN -- adds a
//               hold counter that force-releases a grant after TIMEOUT busy
//               cycles and pulses the timeout output.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-low reset
//               enable   - permits new grants when high
//               last_idx - highest eligible requester index
//               req      - per-requester request levels
//               done     - pulse ending the current grant
//               gnt      - registered one-hot grant
//               gnt_id   - index of the granted requester (valid while busy)
//               busy     - high while a grant is held
//               timeout  - forced-release pulse (timeout build only)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_scheduler
  import rr_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [IDW-1:0]   last_idx,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
`ifdef RR_SCHEDULER_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             busy
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [IDW-1:0]     ptr;
  logic               release_grant;

  // Clamped window and pointer
  int                 eff_last;
  int                 eff_ptr;

  // Priority search results: hi_* is the first hit at/above the pointer,
  // any_* the first hit from index 0 (used when the search wraps).
  logic               hi_found, any_found;
  logic [IDW-1:0]     hi_idx, any_idx;
  logic               win_found;
  logic [IDW-1:0]     win_idx;

`ifdef RR_SCHEDULER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
`endif

  //--------------------------------------------------------------------------
  // Eligible window and round-robin search
  //--------------------------------------------------------------------------
  always_comb begin
    eff_last  = (int'(last_idx) >= N_REQ) ? N_REQ - 1 : int'(last_idx);
    eff_ptr   = (int'(ptr) > eff_last) ? 0 : int'(ptr);
    hi_found  = 1'b0;
    hi_idx    = '0;
    any_found = 1'b0;
    any_idx   = '0;
    // Scan downward so the lowest qualifying index is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if ((i <= eff_last) && req[i]) begin
        any_found = 1'b1;
        any_idx   = IDW'(i);
        if (i >= eff_ptr) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    win_found = any_found;
    win_idx   = hi_found ? hi_idx : any_idx;
  end

  //--------------------------------------------------------------------------
  // FSM next-state / outputs
  //--------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    gnt_id_d      = gnt_id_q;
    release_grant = 1'b0;
`ifdef RR_SCHEDULER_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          state_d  = BUSY;
          gnt_d    = N_REQ'(1) << win_idx;
          gnt_id_d = win_idx;
`ifdef RR_SCHEDULER_TIMEOUT_EN
          cnt_d    = CW'(1);
`endif
        end
      end
      BUSY: begin
        if (done) begin
          release_grant = 1'b1;
`ifdef RR_SCHEDULER_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT)) begin
          release_grant = 1'b1;
          timeout_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
`endif
        end
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = '0;
`ifdef RR_SCHEDULER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

`ifdef RR_SCHEDULER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  //--------------------------------------------------------------------------
  // Pointer: advances past the released requester, wrapping at last_idx
  //--------------------------------------------------------------------------
  circular_adder #(
    .WIDTH (IDW)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .enable_i (release_grant),
    .max_i    (IDW'(eff_last)),
    .base_i   (gnt_id_q),
    .value_o  (ptr)
  );

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = (state_q == BUSY);

endmodule

`default_nettype wire
